// File: rtl/PKG_pwm.sv
// PWM shared package.
// Holds the PWM on/off state type used across the PWM timers, and the default
// sizing for the carrier clock-enable source selector (pwm_clkdiv_sel).
package PKG_pwm;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

  localparam int unsigned CLKSEL_NSRC_DEF  = 4;
  localparam int unsigned CLKSEL_DIV_W_DEF = 16;

endpackage

// File: rtl/clk_div_tick.sv
// Single programmable prescaler for the carrier clock-enable selector.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset, clears the counter
//   div     - divide ratio; 0 and 1 both tick every cycle
//   restart - clears the counter on this edge (takes priority over the tick)
//   tick    - combinational tick, high in the cycle the counter reaches div-1
module clk_div_tick
  import PKG_pwm::*;
#(
  parameter int unsigned DIV_W = CLKSEL_DIV_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic             restart,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  // '>=' rather than '==' so a divider lowered below the running count ticks
  // immediately instead of wrapping through the full counter range.
  assign tick = (div <= DIV_W'(1)) || (r_cnt >= (div - DIV_W'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (restart || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pwm_clkdiv_sel.sv
// Clock-enable source selector for the PWM carrier timers.
// Derives N_SRC prescaler ticks from the system clock and forwards the selected
// one as a registered one-cycle enable. Source changes are applied glitch-free:
// at once while the PWM is off, otherwise at a carrier boundary (carr_zero).
// Build option: CLKSEL_BOUNDARY_SWITCH_EN -- when undefined, switching only
// happens while the PWM is off and carr_zero is ignored.
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   pwm_onoff    - PWM on/off state
//   div          - per-source divide ratios
//   sel, sel_wr  - requested source index and its capture strobe
//   carr_zero    - carrier boundary pulse
//   clk_en       - registered enable tick of the active source
//   sel_active   - source currently driving clk_en
//   sel_pending  - a captured request is waiting to be applied
//   sel_err      - registered pulse for a write of an out-of-range index
module pwm_clkdiv_sel
  import PKG_pwm::*;
#(
  parameter  int unsigned N_SRC = CLKSEL_NSRC_DEF,
  parameter  int unsigned DIV_W = CLKSEL_DIV_W_DEF,
  localparam int unsigned SEL_W = $clog2(N_SRC)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  _pwm_onoff                   pwm_onoff,
  input  logic [N_SRC-1:0][DIV_W-1:0] div,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        sel_wr,
  input  logic                        carr_zero,
  output logic                        clk_en,
  output logic [SEL_W-1:0]            sel_active,
  output logic                        sel_pending,
  output logic                        sel_err
);

  localparam int unsigned N_PAD = 1 << SEL_W;

  logic [N_PAD-1:0] w_tick;
  logic [N_SRC-1:0] w_restart;
  logic             w_sel_ok;
  logic             w_wr_ok;
  logic             w_cond;
  logic             w_apply;
  logic [SEL_W-1:0] w_req_sel;
  logic [SEL_W-1:0] w_active_d;
  logic [SEL_W-1:0] w_pend_sel_d;
  logic             w_pending_d;

  logic [SEL_W-1:0] r_active;
  logic [SEL_W-1:0] r_pend_sel;
  logic             r_pending;
  logic             r_clk_en;
  logic             r_sel_err;

  // Every index is legal when N_SRC fills the select width.
  if (N_PAD == N_SRC) begin : g_sel_full
    assign w_sel_ok = 1'b1;
  end else begin : g_sel_part
    assign w_sel_ok = (sel < SEL_W'(N_SRC));
  end

  assign w_wr_ok = sel_wr && w_sel_ok;

`ifdef CLKSEL_BOUNDARY_SWITCH_EN
  assign w_cond = (pwm_onoff == PWM_OFF) || carr_zero;
`else
  logic w_unused_carr_zero;
  assign w_unused_carr_zero = carr_zero;
  assign w_cond = (pwm_onoff == PWM_OFF);
`endif

  // A fresh valid write wins over the older pending request on the same edge.
  assign w_req_sel = w_wr_ok ? sel : r_pend_sel;
  assign w_apply   = (r_pending || w_wr_ok) && w_cond;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign w_restart[i] = w_apply && (w_req_sel == SEL_W'(i));

    clk_div_tick #(
      .DIV_W(DIV_W)
    ) u_tick (
      .clk    (clk),
      .reset  (reset),
      .div    (div[i]),
      .restart(w_restart[i]),
      .tick   (w_tick[i])
    );
  end

  if (N_PAD > N_SRC) begin : g_pad
    assign w_tick[N_PAD-1:N_SRC] = '0;
  end

  always_comb begin
    w_active_d   = r_active;
    w_pend_sel_d = r_pend_sel;
    w_pending_d  = r_pending;
    if (w_apply) begin
      w_active_d  = w_req_sel;
      w_pending_d = 1'b0;
    end else if (w_wr_ok) begin
      w_pend_sel_d = sel;
      w_pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active   <= '0;
      r_pend_sel <= '0;
      r_pending  <= 1'b0;
      r_clk_en   <= 1'b0;
      r_sel_err  <= 1'b0;
    end else begin
      r_active   <= w_active_d;
      r_pend_sel <= w_pend_sel_d;
      r_pending  <= w_pending_d;
      // Uses the pre-switch source, so a tick from the old source in the cycle
      // before the switch edge is still delivered.
      r_clk_en   <= w_tick[r_active];
      r_sel_err  <= sel_wr && !w_sel_ok;
    end
  end

  assign clk_en      = r_clk_en;
  assign sel_active  = r_active;
  assign sel_pending = r_pending;
  assign sel_err     = r_sel_err;

endmodule

// File: tb/tb_pwm_clkdiv_sel.sv
module tb_pwm_clkdiv_sel;
  import PKG_pwm::*;

`ifdef CLKSEL_BOUNDARY_SWITCH_EN
  localparam bit BSW = 1'b1;
`else
  localparam bit BSW = 1'b0;
`endif

  typedef struct {
    bit         pwm_on;
    bit         wr;
    logic [1:0] sel;
    bit         cz;
    bit         en;
    logic [1:0] act;
    bit         pend;
  } vec_t;

  typedef struct {
    string      name;
    bit         en;
    logic [1:0] act;
    bit         pend;
    bit         err;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  _pwm_onoff           pwm_onoff;
  logic [3:0][15:0]    div;
  logic [1:0]          sel;
  logic                sel_wr;
  logic                carr_zero;
  logic                clk_en;
  logic [1:0]          sel_active;
  logic                sel_pending;
  logic                sel_err;

  _pwm_onoff           pwm3;
  logic [2:0][15:0]    div3;
  logic [1:0]          sel3;
  logic                wr3;
  logic                en3;
  logic [1:0]          act3;
  logic                pend3;
  logic                err3;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  vec_t tab[$];

  always #5 clk = ~clk;

  pwm_clkdiv_sel #(.N_SRC(4), .DIV_W(16)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_onoff  (pwm_onoff),
    .div        (div),
    .sel        (sel),
    .sel_wr     (sel_wr),
    .carr_zero  (carr_zero),
    .clk_en     (clk_en),
    .sel_active (sel_active),
    .sel_pending(sel_pending),
    .sel_err    (sel_err)
  );

  // Three-source instance so out-of-range indices are representable.
  pwm_clkdiv_sel #(.N_SRC(3), .DIV_W(16)) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .pwm_onoff  (pwm3),
    .div        (div3),
    .sel        (sel3),
    .sel_wr     (wr3),
    .carr_zero  (1'b0),
    .clk_en     (en3),
    .sel_active (act3),
    .sel_pending(pend3),
    .sel_err    (err3)
  );

  function automatic void check(input string name, input logic [31:0] got,
                                input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endfunction

  function automatic vec_t mk(input bit pwm_on, input bit wr, input logic [1:0] s,
                              input bit cz, input bit en, input logic [1:0] act,
                              input bit pend);
    vec_t v;
    v.pwm_on = pwm_on; v.wr = wr; v.sel = s; v.cz = cz;
    v.en = en; v.act = act; v.pend = pend;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expected outputs, compare after the edge.
  task automatic step(input string nm, input bit pwm_on, input bit wr, input logic [1:0] s,
                      input bit cz, input bit e_en, input logic [1:0] e_act,
                      input bit e_pend, input bit e_err);
    exp_t e;
    pwm_onoff = pwm_on ? PWM_ON : PWM_OFF;
    sel_wr    = wr;
    sel       = s;
    carr_zero = cz;
    e.name = nm; e.en = e_en; e.act = e_act; e.pend = e_pend; e.err = e_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, " clk_en"}, 32'(clk_en), 32'(e.en));
    check({e.name, " sel_active"}, 32'(sel_active), 32'(e.act));
    check({e.name, " sel_pending"}, 32'(sel_pending), 32'(e.pend));
    check({e.name, " sel_err"}, 32'(sel_err), 32'(e.err));
  endtask

  task automatic run_tab(input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      step($sformatf("%s[%0d]", tag, i), tab[i].pwm_on, tab[i].wr, tab[i].sel, tab[i].cz,
           tab[i].en, tab[i].act, tab[i].pend, 1'b0);
    end
    tab = {};
  endtask

  task automatic step3(input string nm, input bit pwm_on, input bit wr, input logic [1:0] s,
                       input logic [1:0] e_act, input bit e_pend, input bit e_err);
    pwm3 = pwm_on ? PWM_ON : PWM_OFF;
    wr3  = wr;
    sel3 = s;
    @(posedge clk);
    #1;
    check({nm, " clk_en"}, 32'(en3), 32'd1);
    check({nm, " sel_active"}, 32'(act3), 32'(e_act));
    check({nm, " sel_pending"}, 32'(pend3), 32'(e_pend));
    check({nm, " sel_err"}, 32'(err3), 32'(e_err));
  endtask

  initial begin
    reset = 1'b0; pwm_onoff = PWM_OFF; div = '0; sel = '0; sel_wr = 1'b0; carr_zero = 1'b0;
    pwm3 = PWM_ON; div3 = '0; sel3 = '0; wr3 = 1'b0;
    #2 reset = 1'b1;

    // Reset held with random inputs: outputs stay cleared.
    for (int i = 0; i < 4; i++) begin
      div = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      step($sformatf("rst[%0d]", i), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
           1'b0, 2'd0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    div   = {16'd0, 16'd5, 16'd2, 16'd1};

    // Divide rates, PWM off: source 2 (div 5) then source 3 (div 0).
    tab.push_back(mk(0, 0, 0, 0, 1, 0, 0));
    tab.push_back(mk(0, 1, 2, 0, 1, 2, 0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0, 0, 0, 0, 0, 2, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 2, 0));
    for (int i = 0; i < 4; i++) tab.push_back(mk(0, 0, 0, 0, 0, 2, 0));
    tab.push_back(mk(0, 0, 0, 0, 1, 2, 0));
    tab.push_back(mk(0, 1, 3, 0, 0, 3, 0));
    for (int i = 0; i < 3; i++) tab.push_back(mk(0, 0, 0, 0, 1, 3, 0));
    tab.push_back(mk(0, 1, 3, 0, 1, 3, 0));
    run_tab("rate");

    // Deferred switch: source 0 (div 4) to source 1 (div 3) while running.
    div = {16'd0, 16'd5, 16'd3, 16'd4};
    tab.push_back(mk(0, 1, 0, 0, 1, 0, 0));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 1));
    tab.push_back(mk(1, 0, 0, 0, 0, 0, 1));
    tab.push_back(mk(1, 0, 0, 0, 1, 0, 1));
    tab.push_back(mk(1, 0, 0, 1, 0, BSW ? 2'd1 : 2'd0, !BSW));
    tab.push_back(mk(1, 0, 0, 0, 0, BSW ? 2'd1 : 2'd0, !BSW));
    tab.push_back(mk(1, 0, 0, 0, 0, BSW ? 2'd1 : 2'd0, !BSW));
    tab.push_back(mk(1, 0, 0, 0, 1, BSW ? 2'd1 : 2'd0, !BSW));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    run_tab("defer");

    // Overwrite before apply, then a write coinciding with a boundary.
    tab.push_back(mk(0, 1, 0, 0, 0, 0, 0));
    tab.push_back(mk(1, 1, 2, 0, 0, 0, 1));
    tab.push_back(mk(1, 1, 1, 0, 0, 0, 1));
    tab.push_back(mk(1, 0, 0, 1, 0, BSW ? 2'd1 : 2'd0, !BSW));
    tab.push_back(mk(0, 0, 0, 0, !BSW, 1, 0));
    tab.push_back(mk(0, 0, 0, 0, 0, 1, 0));
    tab.push_back(mk(1, 1, 2, 1, BSW, BSW ? 2'd2 : 2'd1, !BSW));
    tab.push_back(mk(0, 0, 0, 0, !BSW, 2, 0));
    run_tab("ovw");

    // Shrinking divider: 100 lowered to 10 with the counter at 50.
    div[0] = 16'd100;
    step("shr_sel", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 50; k++) step($sformatf("shr_c%0d", k), 0, 0, 0, 0, 0, 0, 0, 0);
    div[0] = 16'd10;
    step("shr_drop", 0, 0, 0, 0, 1, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 9; k++) step($sformatf("shr_p%0d_%0d", p, k), 0, 0, 0, 0, 0, 0, 0, 0);
      step($sformatf("shr_p%0d_tick", p), 0, 0, 0, 0, 1, 0, 0, 0);
    end

    // Reset while a switch is pending and the PWM runs.
    div[0] = 16'd3;
    div[1] = 16'd3;
    step("mrst_a", 0, 1, 1, 0, 0, 1, 0, 0);
    step("mrst_b", 1, 1, 2, 0, 0, 1, 1, 0);
    reset = 1'b1;
    #1;
    check("mrst_async clk_en", 32'(clk_en), 32'd0);
    check("mrst_async sel_active", 32'(sel_active), 32'd0);
    check("mrst_async sel_pending", 32'(sel_pending), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      step($sformatf("mrst_p%0d_0", p), 1, 0, 0, 0, 0, 0, 0, 0);
      step($sformatf("mrst_p%0d_1", p), 1, 0, 0, 0, 0, 0, 0, 0);
      step($sformatf("mrst_p%0d_t", p), 1, 0, 0, 0, 1, 0, 0, 0);
    end

    // Invalid index on the three-source instance.
    step3("inv_a", 1, 1, 3, 0, 0, 1);
    step3("inv_b", 1, 0, 0, 0, 0, 0);
    step3("inv_c", 1, 1, 2, 0, 1, 0);
    step3("inv_d", 0, 1, 3, 2, 0, 1);
    step3("inv_e", 0, 0, 0, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
